// File: rtl/rle_dec_if.sv
// Ready/valid stream bundle used for both the compressed input and the expanded output.
interface rle_dec_if #(
  parameter int unsigned DW = 32
) ();
  logic          valid;
  logic [DW-1:0] data;
  logic          ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/rle_dec.sv
// Run-length decoder: expands value/count word streams back into one word per sample.
module rle_dec #(
  parameter int unsigned DW = 32,
  parameter int unsigned CW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          arm,
  input  logic [3:0]    disabledGroups,
  rle_dec_if.slave      sti,
  rle_dec_if.master     sto,
  output logic          busy,
  output logic          err_orphan,
  output logic [CW-1:0] sample_cnt
);

  typedef enum logic [1:0] {StEmpty, StHold, StRepeat} state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] held_q, held_d;
  logic [DW-1:0] rpt_q, rpt_d;
  logic          sto_valid_q, sto_valid_d;
  logic [DW-1:0] sto_data_q, sto_data_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [2:0]    n_en;
  logic [4:0]    fpos;
  logic [DW-1:0] val_mask;
  logic [DW-1:0] masked;
  logic          is_cnt;
  logic          slot_free;
  logic          accept;

  // Flag position and field mask derived from the number of enabled groups.
  always_comb begin
    n_en = 3'(!disabledGroups[0]) + 3'(!disabledGroups[1]) +
           3'(!disabledGroups[2]) + 3'(!disabledGroups[3]);
    case (n_en)
      3'd1:    fpos = 5'd7;
      3'd2:    fpos = 5'd15;
      default: fpos = 5'd31;
    endcase
    val_mask = (DW'(1) << fpos) - DW'(1);
    masked   = sti.data & val_mask;
    is_cnt   = sti.data[fpos];
  end

  assign slot_free = !sto_valid_q || sto.ready;
  assign sti.ready = slot_free && (state_q != StRepeat) && !arm;
  assign accept    = sti.valid && sti.ready;

  // Next-state: arm clear, repeat expansion, word classification and sample counting.
  always_comb begin
    state_d     = state_q;
    held_d      = held_q;
    rpt_d       = rpt_q;
    sto_valid_d = sto_valid_q;
    sto_data_d  = sto_data_q;
    err_d       = err_q;
    cnt_d       = cnt_q;

    if (sto_valid_q && sto.ready && (cnt_q != '1)) cnt_d = cnt_q + CW'(1);
    if (slot_free) sto_valid_d = 1'b0;

    if (arm) begin
      state_d     = StEmpty;
      rpt_d       = '0;
      sto_valid_d = 1'b0;
      err_d       = 1'b0;
      cnt_d       = '0;
    end else if (state_q == StRepeat) begin
      if (slot_free) begin
        sto_valid_d = 1'b1;
        sto_data_d  = held_q;
        rpt_d       = rpt_q - DW'(1);
        if (rpt_q == DW'(1)) state_d = StHold;
      end
    end else if (accept) begin
      if (!enable) begin
        // Pass-through: raw word, state untouched.
        sto_valid_d = 1'b1;
        sto_data_d  = sti.data;
      end else if (!is_cnt) begin
        held_d      = masked;
        sto_valid_d = 1'b1;
        sto_data_d  = masked;
        state_d     = StHold;
      end else if (state_q == StEmpty) begin
        err_d = 1'b1;
      end else if (masked != '0) begin
        rpt_d   = masked;
        state_d = StRepeat;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StEmpty;
      held_q      <= '0;
      rpt_q       <= '0;
      sto_valid_q <= 1'b0;
      sto_data_q  <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      held_q      <= held_d;
      rpt_q       <= rpt_d;
      sto_valid_q <= sto_valid_d;
      sto_data_q  <= sto_data_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign sto.valid  = sto_valid_q;
  assign sto.data   = sto_data_q;
  assign busy       = (state_q == StRepeat);
  assign err_orphan = err_q;
  assign sample_cnt = cnt_q;

endmodule

// File: doc/rle_dec.md
Name: rle_dec

Overview:
- Run-length decoder: the inverse of the capture path's RLE encoder.
- Accepts the compressed stream of value words and count words and re-expands it into one word per original sample.
- Sits on the readback/loopback path (memory readout -> rle_dec -> test pattern checker or re-trigger evaluation) in the core clock domain.
- Supports the same channel-group width modes as the encoder, with ready/valid backpressure on both sides.

Parameters:
- DW, 32, sample data width. Must be 32; group modes assume 4 x 8-bit groups.
- CW, 32, width of the expanded-sample counter.

Ports:
- clk  input  1  core clock
- rst_n  input  1  asynchronous, active-low reset
- enable  input  1  1 = decode RLE; 0 = transparent pass-through
- arm  input  1  synchronous clear of decoder state (new capture)
- disabledGroups  input  4  channel groups excluded from capture; selects the flag bit position
- sti_valid  input  1  input word valid
- sti_data  input  DW  compressed input word
- sti_ready  output  1  decoder accepts sti_data this cycle
- sto_valid  output  1  expanded sample valid
- sto_data  output  DW  expanded sample
- sto_ready  input  1  downstream accepts sto_data
- busy  output  1  repeat expansion in progress
- err_orphan  output  1  sticky: count word received with no preceding value
- sample_cnt  output  CW  number of samples emitted since arm, saturating

Behaviour:
- Reset (rst_n low, async) values:
  - sto_valid=0, sto_data=0, busy=0, err_orphan=0, sample_cnt=0.
  - State = EMPTY; held value = 0; repeat counter = 0.
- Flag bit position F and count field width, from the number of enabled groups (zeros in disabledGroups):
  - 1 group: F=7, count = bits [6:0].
  - 2 groups: F=15, count = bits [14:0].
  - 3, 4 or 0 groups: F=31, count = bits [30:0].
  - Bits above F are ignored on input and driven 0 on output.
- Word classification: value word when bit F=0; count word when bit F=1. Count N means "emit the held value N more times".
- Output is a single registered stage. The slot is free when sto_valid=0 or sto_ready=1.
- sti_ready = slot free AND state != REPEAT.
- States:
  - EMPTY: no held value.
    - Value word accepted -> held value = word with bits >= F cleared, emit it, go to HOLD.
    - Count word accepted -> discard, set err_orphan, stay in EMPTY.
  - HOLD: held value valid.
    - Value word -> replace held value, emit it, stay in HOLD.
    - Count word with N=0 -> consumed, no emission, stay in HOLD.
    - Count word with N>=1 -> load counter=N, go to REPEAT; nothing emitted in the accept cycle.
  - REPEAT:
    - Each cycle the slot is free, emit the held value and decrement the counter.
    - When the counter reaches 0 after a decrement, return to HOLD. sti_ready is 0 for the whole of REPEAT.
    - A count word arriving after REPEAT completes re-enters REPEAT with the same held value.
- Latency:
  - Accepted value word appears on sto_data the next cycle.
  - First repeat beat appears 2 cycles after the count word is accepted, given sto_ready=1.
  - Steady-state throughput is 1 word/cycle.
- busy = (state == REPEAT).
- sample_cnt increments on every sto_valid && sto_ready handshake and saturates at all-ones.
- enable=0:
  - Every accepted word is forwarded unmodified with 1-cycle latency; no flag interpretation and no masking.
  - State stays EMPTY and err_orphan is unchanged.
  - Changing enable while in REPEAT takes effect only after REPEAT completes.
- arm=1 (sync, highest priority after reset):
  - State = EMPTY; counter = 0; sto_valid = 0; err_orphan = 0; sample_cnt = 0.
  - sti_ready = 0 in the arm cycle; the input word, if any, is not consumed.
- Backpressure: while sto_valid=1 and sto_ready=0, sto_data, the counter and the state hold stable.
- disabledGroups must be static between arm pulses. Changing it mid-stream gives undefined decode but no lockup.

Test Plan:
- 4 groups enabled, enable=1; input 0x00000012, 0x80000003, 0x00000034 -> output 0x12, 0x12, 0x12, 0x12, 0x34; sample_cnt=5; err_orphan=0.
- 1 group enabled (disabledGroups=4'b1110); input 0x05, 0x82, 0x80 -> output 0x05, 0x05, 0x05; the count-0 word emits nothing; bits [31:8] of sto_data = 0.
- Orphan: after arm, input 0x80000007 then 0x00000001 -> err_orphan=1, output only 0x00000001; next arm clears err_orphan.
- Backpressure: input 0x0000AAAA then count 4; sto_ready toggles 1,0,0,1,1,0,1 -> exactly 5 beats of 0xAAAA; sti_ready=0 throughout REPEAT; no beat lost or duplicated.
- enable=0: input 0x80000003, 0x00000009 -> output 0x80000003, 0x00000009 unchanged; sample_cnt=2.
- Mid-operation resets: arm asserted during REPEAT (counter=100) -> next cycle sto_valid=0, busy=0, sample_cnt=0. rst_n pulsed low mid-stream -> all outputs 0 immediately, without waiting for a clock edge.
